// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDivBusy = 2'd1,
    StDivHold = 2'd2
  } div_state_e;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;

  localparam int unsigned DIV_LAT_DEFAULT = 32;

endpackage

// File: rtl/pipe_stall_ctrl_div_seq.sv
// Divider sequencer: countdown plus start/cancel/valid generation and the busy/hold FSM.
module pipe_stall_ctrl_div_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_e_i,
  input  logic d_wait_i,
  input  logic exc_m_i,
  output logic div_start_o,
  output logic div_cancel_o,
  output logic div_valid_o,
  output logic div_stall_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_start_o  = 1'b0;
    div_cancel_o = 1'b0;
    div_valid_o  = 1'b0;
    div_stall_o  = 1'b0;
    if (exc_m_i) begin
      div_cancel_o = (state_q != StRun);
      state_d      = StRun;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          // A frozen pipeline keeps the divide in E, so launch once the freeze lifts.
          if (div_e_i && !d_wait_i) begin
            div_start_o = 1'b1;
            div_stall_o = 1'b1;
            // The launch cycle is the first latency cycle; cnt==0 marks the result cycle.
            cnt_d       = CNT_W'(DIV_LAT - 2);
            state_d     = StDivBusy;
          end
        end
        StDivBusy: begin
          if (!cnt_zero) begin
            cnt_d       = cnt_q - CNT_W'(1);
            div_stall_o = 1'b1;
          end else begin
            div_valid_o = 1'b1;
            state_d     = d_wait_i ? StDivHold : StRun;
          end
        end
        StDivHold: begin
          div_valid_o = 1'b1;
          if (!d_wait_i) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
    if (!resetn) begin
      div_start_o  = 1'b0;
      div_cancel_o = 1'b0;
      div_valid_o  = 1'b0;
      div_stall_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush scheduler: priority merge of hazard, SRAM, divider and exception events.
// Optional STALL_PERF_CNT_EN adds the stall_cnt_o stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hz_stall_i,
  input  logic        div_e_i,
  input  logic        i_wait_i,
  input  logic        d_wait_i,
  input  logic        exc_m_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        div_valid_o,
  output logic        redirect_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  logic div_stall;

  pipe_stall_ctrl_div_seq #(
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_div_seq (
    .clk         (clk),
    .resetn      (resetn),
    .div_e_i     (div_e_i),
    .d_wait_i    (d_wait_i),
    .exc_m_i     (exc_m_i),
    .div_start_o (div_start_o),
    .div_cancel_o(div_cancel_o),
    .div_valid_o (div_valid_o),
    .div_stall_o (div_stall)
  );

  always_comb begin
    stall_o    = '0;
    flush_o    = '0;
    redirect_o = 1'b0;
    if (!resetn) begin
      stall_o = '0;
    end else if (exc_m_i) begin
      // W holds the older instruction and is allowed to retire.
      redirect_o     = 1'b1;
      flush_o[STG_D] = 1'b1;
      flush_o[STG_E] = 1'b1;
      flush_o[STG_M] = 1'b1;
    end else begin
      if (d_wait_i) begin
        stall_o[STG_M:STG_F] = 4'b1111;
        flush_o[STG_W]       = 1'b1;
      end
      if (div_stall) begin
        stall_o[STG_E:STG_F] = 3'b111;
        flush_o[STG_M]       = 1'b1;
      end
      if (i_wait_i) begin
        stall_o[STG_F] = 1'b1;
        flush_o[STG_D] = 1'b1;
      end
      if (hz_stall_i) begin
        stall_o[STG_D:STG_F] = 2'b11;
        flush_o[STG_E]       = 1'b1;
      end
      // A held stage must keep its contents, so it can never take a bubble.
      flush_o = flush_o & ~stall_o;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o[STG_F]) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a cycle-time behavioural model and literal pins.
module tb_pipe_stall_ctrl;

  localparam int unsigned DivLat = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       hz_stall_i = 1'b0;
  logic       div_e_i = 1'b0;
  logic       i_wait_i = 1'b0;
  logic       d_wait_i = 1'b0;
  logic       exc_m_i = 1'b0;
  logic [4:0] stall_o, flush_o;
  logic       div_start_o, div_cancel_o, div_valid_o, redirect_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .DIV_LAT(DivLat),
    .CNT_W  (6)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .hz_stall_i  (hz_stall_i),
    .div_e_i     (div_e_i),
    .i_wait_i    (i_wait_i),
    .d_wait_i    (d_wait_i),
    .exc_m_i     (exc_m_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .div_start_o (div_start_o),
    .div_cancel_o(div_cancel_o),
    .div_valid_o (div_valid_o),
    .redirect_o  (redirect_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          t = 0;
  bit          m_busy = 1'b0;
  int          m_ready_at = 0;
  logic [31:0] m_cnt = '0;

  logic [4:0] s_stall, s_flush;
  logic       s_start, s_cancel, s_valid, s_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance the model.
  task automatic step(input logic rn, input logic de, input logic iw, input logic dw,
                      input logic ex, input logic hz);
    logic [4:0] e_stall, e_flush;
    logic       e_start, e_cancel, e_valid, e_redir, res_ready, dstall;
    resetn = rn; div_e_i = de; i_wait_i = iw; d_wait_i = dw; exc_m_i = ex; hz_stall_i = hz;
    @(negedge clk);
    s_stall = stall_o; s_flush = flush_o; s_start = div_start_o;
    s_cancel = div_cancel_o; s_valid = div_valid_o; s_redir = redirect_o;
    e_stall = '0; e_flush = '0; e_start = 0; e_cancel = 0; e_valid = 0; e_redir = 0;
    res_ready = m_busy && (t >= m_ready_at);
    if (rn) begin
      if (ex) begin
        e_redir  = 1;
        e_flush  = 5'b01110;
        e_cancel = m_busy;
      end else begin
        e_start = !m_busy && de && !dw;
        e_valid = res_ready;
        dstall  = e_start || (m_busy && !res_ready);
        e_stall = (dw ? 5'b01111 : 5'b0) | (dstall ? 5'b00111 : 5'b0) |
                  (iw ? 5'b00001 : 5'b0) | (hz ? 5'b00011 : 5'b0);
        e_flush = {dw, dstall, hz, iw, 1'b0} & ~e_stall;
      end
    end
    chk("stall_o", 32'(s_stall), 32'(e_stall));
    chk("flush_o", 32'(s_flush), 32'(e_flush));
    chk("div_start_o", 32'(s_start), 32'(e_start));
    chk("div_cancel_o", 32'(s_cancel), 32'(e_cancel));
    chk("div_valid_o", 32'(s_valid), 32'(e_valid));
    chk("redirect_o", 32'(s_redir), 32'(e_redir));
`ifdef STALL_PERF_CNT_EN
    chk("stall_cnt_o", stall_cnt_o, m_cnt);
`endif
    if (!rn) begin
      m_busy = 0;
      m_cnt  = '0;
    end else begin
      if (ex) m_busy = 0;
      else if (e_start) begin
        m_busy     = 1;
        m_ready_at = t + DivLat - 1;
      end else if (res_ready && !dw) m_busy = 0;
      if (e_stall[0]) m_cnt = m_cnt + 32'd1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("reset_all_zero", {s_stall, s_flush, s_start, s_cancel, s_valid, s_redir}, 0);
    idle();
    idle();

    step(1, 0, 1, 0, 0, 1);
    chk("hz_iw_stall", s_stall, 5'b00011);
    chk("hz_iw_flush", s_flush, 5'b00100);
    step(1, 0, 0, 0, 0, 1);
    chk("hz_stall", s_stall, 5'b00011);
    chk("hz_flush", s_flush, 5'b00100);
    step(1, 0, 1, 0, 0, 0);
    chk("iw_stall", s_stall, 5'b00001);
    chk("iw_flush", s_flush, 5'b00010);
    idle();

    // Single divide, with an i_wait blip in the middle.
    for (int k = 0; k < 32; k++) begin
      step(1, 1, (k == 12), 0, 0, 0);
      if (k == 0) begin
        chk("div0_start", s_start, 1'b1);
        chk("div0_stall", s_stall, 5'b00111);
      end
      if (k == 30) chk("div30_valid", s_valid, 1'b0);
      if (k == 31) begin
        chk("div31_valid", s_valid, 1'b1);
        chk("div31_stall", s_stall, 5'b00000);
      end
    end
    // Back-to-back divide, with d_wait over cycles 30..34.
    for (int k = 0; k < 36; k++) begin
      step(1, 1, 0, (k >= 30 && k <= 34), 0, 0);
      if (k == 0) chk("b2b_start", s_start, 1'b1);
      if (k == 32) begin
        chk("hold32_stall", s_stall, 5'b01111);
        chk("hold32_valid", s_valid, 1'b1);
      end
      if (k == 35) begin
        chk("hold35_stall", s_stall, 5'b00000);
        chk("hold35_valid", s_valid, 1'b1);
      end
    end
    idle();

    // Exception at divide cycle 10.
    for (int k = 0; k <= 10; k++) begin
      step(1, 1, 0, 0, (k == 10), 0);
    end
    chk("exc_cancel", s_cancel, 1'b1);
    chk("exc_redir", s_redir, 1'b1);
    chk("exc_flush", s_flush, 5'b01110);
    chk("exc_stall", s_stall, 5'b00000);
    idle();
    chk("post_exc_valid", s_valid, 1'b0);
    chk("post_exc_stall", s_stall, 5'b00000);

    // Exception together with d_wait in RUN.
    step(1, 0, 1, 1, 1, 1);
    chk("excdw_redir", s_redir, 1'b1);
    chk("excdw_stall", s_stall, 5'b00000);
    chk("excdw_flush", s_flush, 5'b01110);
    idle();

    // Divide held off by d_wait in RUN, then exception while in hold.
    step(1, 1, 0, 1, 0, 0);
    for (int k = 0; k < 32; k++) step(1, 1, 0, (k == 31), 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    chk("hold_exc_cancel", s_cancel, 1'b1);
    idle();

    // Reset mid-divide.
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_mid_cancel", s_cancel, 1'b0);
    chk("rst_mid_stall", s_stall, 5'b00000);
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_stall", s_stall, 5'b00000);
    chk("post_rst_valid", s_valid, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    chk("post_rst_start", s_start, 1'b1);
    for (int k = 0; k < 34; k++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
